sirv_gnrl_rr_lockarb: RTL

Round-robin arbiter with burst lock that shares one downstream valid/ready channel between N upstream requesters. Each requester presents a beat stream (data plus `last`); the arbiter grants one requester and holds that grant until the offered beat is accepted and, for multi-beat bursts, until the `last` beat is accepted. It sits in front of any shared general resource (bus port, register-file write port, ICB master) in the general library.

---
 rtl/sirv_gnrl_rr_lockarb.sv | 111 +++++++++++
 1 files changed

// File: rtl/sirv_gnrl_rr_lockarb.sv
// Round-robin arbiter with burst lock: shares one downstream valid/ready beat
// channel among N requesters, holding the grant until a stalled offer is taken
// and until the last beat of a burst transfers.
module sirv_gnrl_rr_lockarb #(
  parameter int N  = 4,
  parameter int IW = 2,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    i_ready,
  input  logic [N-1:0]    i_last,
  input  logic [N*DW-1:0] i_dat,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            o_last,
  output logic [IW-1:0]   o_id,
  output logic [DW-1:0]   o_dat
);

  // Handshake: a beat moves when o_valid & o_ready; i_ready[k] is that same
  // acceptance routed back only to the granted requester.

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_e;

  typedef struct packed {
    lock_e         lock;
    logic [IW-1:0] lock_id;
    logic [IW-1:0] ptr;
  } arb_state_t;

  arb_state_t    st_q;
  arb_state_t    st_d;
  logic          has_grant;
  logic [IW-1:0] grant;
  logic [IW-1:0] ptr_nxt;
  logic          sel_v;
  logic          sel_l;
  logic [DW-1:0] sel_d;

  // Rotating search: walk offsets from far to near so offset 0 from ptr wins.
  always_comb begin
    has_grant = 1'b0;
    grant     = '0;
    if (st_q.lock == ARB_LOCKED) begin
      has_grant = 1'b1;
      grant     = st_q.lock_id;
    end else begin
      for (int off = N - 1; off >= 0; off--) begin
        for (int k = 0; k < N; k++) begin
          if ((k == ((int'(st_q.ptr) + off) % N)) && i_valid[k]) begin
            has_grant = 1'b1;
            grant     = IW'(k);
          end
        end
      end
    end
  end

  always_comb begin
    sel_v = 1'b0;
    sel_l = 1'b0;
    sel_d = '0;
    for (int k = 0; k < N; k++) begin
      if (has_grant && (k == int'(grant))) begin
        sel_v = i_valid[k];
        sel_l = i_last[k];
        sel_d = i_dat[k*DW +: DW];
      end
    end
  end

  // Outputs are forced to zero for the whole time reset is high.
  always_comb begin
    o_valid = sel_v & ~rst;
    o_last  = o_valid & sel_l;
    o_id    = o_valid ? grant : '0;
    o_dat   = o_valid ? sel_d : '0;
    i_ready = '0;
    for (int k = 0; k < N; k++) begin
      i_ready[k] = o_ready & o_valid & (k == int'(grant));
    end
  end

  assign ptr_nxt = (int'(grant) >= N - 1) ? '0 : grant + IW'(1);

  always_comb begin
    st_d = st_q;
    if (o_valid && o_ready && o_last) begin
      st_d.lock = ARB_OPEN;
      st_d.ptr  = ptr_nxt;
    end else if (o_valid) begin
      // Mid-burst transfer or stalled offer: pin the grant to this requester.
      st_d.lock    = ARB_LOCKED;
      st_d.lock_id = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '{lock: ARB_OPEN, lock_id: '0, ptr: '0};
    end else begin
      st_q <= st_d;
    end
  end

endmodule
